// File: rtl/alu_result_tx_pkg.sv
// Shared encodings and frame constants for the ALU result UART transmitter.
package alu_result_tx_pkg;
  localparam int   NB_FRAME_DATA = 8;
  localparam logic START_BIT     = 1'b0;
  localparam logic STOP_BIT      = 1'b1;
  localparam logic IDLE_LEVEL    = 1'b1;

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_DONE} tx_state_e;
  typedef enum logic [1:0] {SEQ_IDLE, SEQ_BUSY, SEQ_DONE} seq_state_e;

  // Second frame payload: bit0 = zero, bit1 = carry, upper bits clear.
  function automatic logic [NB_FRAME_DATA-1:0] flags_byte(input logic carry, input logic zero);
    return {{(NB_FRAME_DATA-2){1'b0}}, carry, zero};
  endfunction
endpackage

// File: rtl/alu_result_tx_uart_tx_byte.sv
// Single 8N1 frame serializer with its own baud counter.
module uart_tx_byte
  import alu_result_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter int NB_CNT       = 13
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [NB_FRAME_DATA-1:0] data,
  output logic                     tx,
  output logic                     busy,
  output logic                     frame_done
);
  localparam logic [NB_CNT-1:0] CNT_MAX = NB_CNT'(CLKS_PER_BIT - 1);

  tx_state_e                state;
  logic [NB_CNT-1:0]        cnt;
  logic [2:0]               bit_idx;
  logic [NB_FRAME_DATA-1:0] shreg;
  logic                     bit_end;

  assign bit_end    = (cnt == CNT_MAX);
  assign busy       = (state != ST_IDLE);
  // Flags the last cycle of the stop bit so the sequencer can chain the next frame gaplessly.
  assign frame_done = (state == ST_STOP) && bit_end;

  // data is sampled at the end of the start bit, so the caller only has to hold it until then.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= IDLE_LEVEL;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (start) begin
            state <= ST_START;
            tx    <= START_BIT;
          end
        end
        ST_START: begin
          if (bit_end) begin
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= data;
            tx      <= data[0];
            state   <= ST_DATA;
          end else cnt <= cnt + 1'b1;
        end
        ST_DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == 3'(NB_FRAME_DATA - 1)) begin
              tx    <= STOP_BIT;
              state <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shreg   <= {1'b0, shreg[NB_FRAME_DATA-1:1]};
              tx      <= shreg[1];
            end
          end else cnt <= cnt + 1'b1;
        end
        ST_STOP: begin
          if (bit_end) begin
            cnt <= '0;
            if (start) begin
              tx    <= START_BIT;
              state <= ST_START;
            end else state <= ST_IDLE;
          end else cnt <= cnt + 1'b1;
        end
        default: begin
          state <= ST_IDLE;
          tx    <= IDLE_LEVEL;
          cnt   <= '0;
        end
      endcase
    end
  end
endmodule

// File: rtl/alu_result_tx.sv
// Two-byte sequencer: captures ALU result/flags on accept and sends them as
// back-to-back UART frames (result, then {0.., carry, zero}).
module alu_result_tx
  import alu_result_tx_pkg::*;
#(
  parameter int NB_DATA      = 8,
  parameter int CLKS_PER_BIT = 5208,
  parameter int NB_CNT       = 13
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_valid,
  input  logic [NB_DATA-1:0] i_result,
  input  logic               i_carry,
  input  logic               i_zero,
  output logic               o_ready,
  output logic               o_tx,
  output logic               o_done
);
  seq_state_e               state;
  logic [NB_DATA-1:0]       res_q;
  logic                     carry_q;
  logic                     zero_q;
  logic                     byte_sel;
  logic                     accept;
  logic                     start;
  logic                     busy;
  logic                     frame_done;
  logic [NB_FRAME_DATA-1:0] tx_byte;

  assign accept  = i_valid && o_ready;
  assign start   = accept || ((state == SEQ_BUSY) && frame_done && !byte_sel);
  assign tx_byte = byte_sel ? flags_byte(carry_q, zero_q) : res_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= SEQ_IDLE;
      res_q    <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      byte_sel <= 1'b0;
      o_ready  <= 1'b1;
      o_done   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        SEQ_BUSY: begin
          if (frame_done) begin
            if (byte_sel) begin
              state   <= SEQ_DONE;
              o_done  <= 1'b1;
              o_ready <= 1'b1;
            end else byte_sel <= 1'b1;
          end
        end
        default: begin
          // IDLE and DONE both accept; leaving DONE on an accept gives back-to-back sends.
          if (accept) begin
            res_q    <= i_result;
            carry_q  <= i_carry;
            zero_q   <= i_zero;
            byte_sel <= 1'b0;
            o_ready  <= 1'b0;
            state    <= SEQ_BUSY;
          end else state <= SEQ_IDLE;
        end
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .NB_CNT      (NB_CNT)
  ) u_tx_byte (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .data      (tx_byte),
    .tx        (o_tx),
    .busy      (busy),
    .frame_done(frame_done)
  );

  // The sequencer never starts a frame while the serializer is mid-frame.
  always_ff @(posedge clk) begin
    if (rst_n && accept) assert (!busy);
  end
endmodule

// File: tb/tb_alu_result_tx.sv
// Directed bench for alu_result_tx at 4 clocks per UART bit.
module tb_alu_result_tx;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_valid;
  logic [7:0] i_result;
  logic       i_carry;
  logic       i_zero;
  logic       o_ready;
  logic       o_tx;
  logic       o_done;

  int n_chk = 0;
  int n_fail = 0;

  logic tx_s  [0:199];
  logic rdy_s [0:199];
  logic dn_s  [0:199];
  int   done_cnt;
  int   first_done;

  always #5 clk = ~clk;

  alu_result_tx #(.NB_DATA(8), .CLKS_PER_BIT(CPB), .NB_CNT(2)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_result(i_result),
    .i_carry(i_carry), .i_zero(i_zero), .o_ready(o_ready), .o_tx(o_tx), .o_done(o_done)
  );

  // Sets inputs while o_ready is high and lets the next edge accept them.
  task automatic do_accept(input logic [7:0] res, input logic c, input logic z, input logic hold);
    int t = 0;
    @(negedge clk);
    while (!o_ready && t < 200) begin @(negedge clk); t++; end
    n_chk++;
    if (!o_ready) begin n_fail++; $display("FAIL accept_wait: o_ready=%b required 1", o_ready); end
    i_result = res; i_carry = c; i_zero = z; i_valid = 1'b1;
    @(posedge clk);
    #1 if (!hold) i_valid = 1'b0;
  endtask

  // Records outputs at the negedge of cycles 1..ncyc after the accept edge; optionally
  // drives i_valid/i_result at cycle poke_cyc (i_valid dropped again one cycle later).
  task automatic run_capture(input int ncyc, input int poke_cyc, input logic poke_valid,
                             input logic [7:0] poke_res);
    done_cnt = 0; first_done = -1;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      tx_s[k] = o_tx; rdy_s[k] = o_ready; dn_s[k] = o_done;
      if (o_done === 1'b1) begin
        done_cnt++;
        if (first_done < 0) first_done = k;
      end
      if (k == poke_cyc) begin i_valid = poke_valid; i_result = poke_res; end
      if (k == poke_cyc + 1) i_valid = 1'b0;
    end
  endtask

  // Level of bit j of a stream starting after cycle base; x if it wobbles inside the bit.
  function automatic logic bit_obs(input int base, input int j);
    logic v = tx_s[base + j*CPB + 1];
    for (int c = 2; c <= CPB; c++)
      if (tx_s[base + j*CPB + c] !== v) return 1'bx;
    return v;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0; i_valid = 1'b0; i_result = 8'h00; i_carry = 1'b0; i_zero = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({o_tx, o_ready, o_done} !== 3'b110) begin
      n_fail++; $display("FAIL reset_state: tx/ready/done=%b required 110", {o_tx, o_ready, o_done});
    end
    rst_n = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      n_chk++;
      if ({o_tx, o_ready, o_done} !== 3'b110) begin
        n_fail++; $display("FAIL idle_hold[%0d]: tx/ready/done=%b required 110", k, {o_tx, o_ready, o_done});
      end
    end
  endtask

  task automatic test_basic_send;
    logic [0:19] exp = 20'b0101001011_0010000001;
    do_accept(8'hA5, 1'b1, 1'b0, 1'b0);
    run_capture(90, 0, 1'b0, 8'h00);
    for (int j = 0; j < 20; j++) begin
      n_chk++;
      if (bit_obs(0, j) !== exp[j]) begin
        n_fail++; $display("FAIL basic_bit[%0d]: got %b required %b", j, bit_obs(0, j), exp[j]);
      end
    end
    n_chk++;
    if (rdy_s[1] !== 1'b0) begin n_fail++; $display("FAIL basic_ready_low: got %b required 0", rdy_s[1]); end
    n_chk++;
    if (first_done != 81) begin n_fail++; $display("FAIL basic_done_time: got %0d required 81", first_done); end
    n_chk++;
    if (done_cnt != 1) begin n_fail++; $display("FAIL basic_done_count: got %0d required 1", done_cnt); end
    n_chk++;
    if ({tx_s[81], rdy_s[81], rdy_s[80]} !== 3'b110) begin
      n_fail++; $display("FAIL basic_done_cycle: tx/ready/ready_prev=%b required 110", {tx_s[81], rdy_s[81], rdy_s[80]});
    end
  endtask

  task automatic test_busy_ignore;
    logic [0:19] exp = 20'b0001111001_0000000001;
    do_accept(8'h3C, 1'b0, 1'b0, 1'b0);
    run_capture(120, 10, 1'b1, 8'hFF);
    for (int j = 0; j < 20; j++) begin
      n_chk++;
      if (bit_obs(0, j) !== exp[j]) begin
        n_fail++; $display("FAIL busy_bit[%0d]: got %b required %b", j, bit_obs(0, j), exp[j]);
      end
    end
    n_chk++;
    if (done_cnt != 1) begin n_fail++; $display("FAIL busy_done_count: got %0d required 1", done_cnt); end
    n_chk++;
    if (tx_s[100] !== 1'b1 || rdy_s[100] !== 1'b1) begin
      n_fail++; $display("FAIL busy_no_second_send: tx=%b ready=%b required 1 1", tx_s[100], rdy_s[100]);
    end
  endtask

  task automatic test_back_to_back;
    logic [0:19] exp = 20'b0000000001_0100000001;
    do_accept(8'h00, 1'b0, 1'b1, 1'b1);
    run_capture(170, 82, 1'b0, 8'h00);
    for (int j = 0; j < 20; j++) begin
      n_chk++;
      if (bit_obs(0, j) !== exp[j] || bit_obs(81, j) !== exp[j]) begin
        n_fail++; $display("FAIL b2b_bit[%0d]: got %b/%b required %b", j, bit_obs(0, j), bit_obs(81, j), exp[j]);
      end
    end
    n_chk++;
    if ({dn_s[81], tx_s[81], rdy_s[81]} !== 3'b111) begin
      n_fail++; $display("FAIL b2b_done_cycle: done/tx/ready=%b required 111", {dn_s[81], tx_s[81], rdy_s[81]});
    end
    n_chk++;
    if ({tx_s[82], rdy_s[82]} !== 2'b00) begin
      n_fail++; $display("FAIL b2b_second_accept: tx/ready=%b required 00", {tx_s[82], rdy_s[82]});
    end
    n_chk++;
    if (done_cnt != 2 || first_done != 81 || dn_s[162] !== 1'b1) begin
      n_fail++; $display("FAIL b2b_done: count=%0d first=%0d d162=%b required 2 81 1", done_cnt, first_done, dn_s[162]);
    end
  endtask

  task automatic test_reset_midframe;
    logic [0:19] exp = 20'b0101001011_0010000001;
    int dn = 0;
    do_accept(8'h00, 1'b0, 1'b0, 1'b0);
    repeat (18) @(negedge clk);  // cycle 18: inside data bit 3 of byte 0
    n_chk++;
    if (o_tx !== 1'b0) begin n_fail++; $display("FAIL mid_pre_reset_tx: got %b required 0", o_tx); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_chk++;
    if ({o_tx, o_ready, o_done} !== 3'b110) begin
      n_fail++; $display("FAIL mid_reset_state: tx/ready/done=%b required 110", {o_tx, o_ready, o_done});
    end
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (o_done === 1'b1 || o_tx !== 1'b1) dn++;
    end
    n_chk++;
    if (dn != 0) begin n_fail++; $display("FAIL mid_quiet_after_reset: got %0d bad cycles required 0", dn); end
    do_accept(8'hA5, 1'b1, 1'b0, 1'b0);
    run_capture(90, 0, 1'b0, 8'h00);
    for (int j = 0; j < 20; j++) begin
      n_chk++;
      if (bit_obs(0, j) !== exp[j]) begin
        n_fail++; $display("FAIL mid_resend_bit[%0d]: got %b required %b", j, bit_obs(0, j), exp[j]);
      end
    end
    n_chk++;
    if (first_done != 81 || done_cnt != 1) begin
      n_fail++; $display("FAIL mid_resend_done: first=%0d count=%0d required 81 1", first_done, done_cnt);
    end
  endtask

  task automatic test_unstable_inputs;
    logic [0:19] exp = 20'b0010110101_0100000001;
    do_accept(8'h5A, 1'b0, 1'b1, 1'b0);
    run_capture(90, 1, 1'b0, 8'hC3);
    i_carry = 1'b1; i_zero = 1'b0;
    for (int j = 0; j < 20; j++) begin
      n_chk++;
      if (bit_obs(0, j) !== exp[j]) begin
        n_fail++; $display("FAIL capture_bit[%0d]: got %b required %b", j, bit_obs(0, j), exp[j]);
      end
    end
    n_chk++;
    if (first_done != 81) begin n_fail++; $display("FAIL capture_done_time: got %0d required 81", first_done); end
  endtask

  initial begin
    test_reset();
    test_basic_send();
    test_busy_ignore();
    test_back_to_back();
    test_reset_midframe();
    test_unstable_inputs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
